lock_attempt_supervisor: RTL and testbench

Controller that sits between the front-panel inputs and the combination lock FSM.
- Forwards unlock presses to the lock as single-cycle pulses.
- Counts failed unlock attempts and imposes a timed lockout after MAX_FAILS failures.
- Resets the lock's sequence after a failure or after dial inactivity.
- Drives the alarm and fail-count indicators.

---
 rtl/lock_pkg.sv | 28 ++
 rtl/lock_timer.sv | 29 ++
 rtl/lock_attempt_supervisor.sv | 148 ++++++++++++++
 tb/tb_lock_attempt_supervisor.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared encodings and default constants for the lock supervisor and the
// combination lock FSM it controls.
package lock_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_WAIT    = 3'd2,
    S_CHECK   = 3'd3,
    S_OPEN    = 3'd4,
    S_LOCKOUT = 3'd5
  } sup_state_e;

  // Combination lock FSM states, kept here so both blocks agree on one encoding.
  typedef enum logic [2:0] {
    LK_START = 3'd0,
    LK_R1    = 3'd1,
    LK_L1    = 3'd2,
    LK_R2    = 3'd3,
    LK_OPEN  = 3'd4
  } lock_state_e;

  localparam int DEF_MAX_FAILS      = 3;
  localparam int DEF_LOCKOUT_CYCLES = 50000000;
  localparam int DEF_IDLE_TIMEOUT   = 25000000;
  localparam int DEF_TMR_W          = 26;

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the inactivity and lockout timeouts.
// Holds at zero instead of wrapping.
module lock_timer #(
  parameter int TMR_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                   cnt_d = load_val;
    else if (dec && cnt_q != '0) cnt_d = cnt_q - TMR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/lock_attempt_supervisor.sv
// Front-panel supervisor for the combination lock: forwards presses, counts
// failed attempts, enforces a timed lockout and abandons idle sequences.
module lock_attempt_supervisor
  import lock_pkg::*;
#(
  parameter int MAX_FAILS      = DEF_MAX_FAILS,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int IDLE_TIMEOUT   = DEF_IDLE_TIMEOUT,
  parameter int TMR_W          = DEF_TMR_W
) (
  input  logic       Clk,
  input  logic       South,
  input  logic       Right,
  input  logic       Left,
  input  logic       Center,
  input  logic       Locked,
  output logic       CenterPulse,
  output logic       LockRst,
  output logic       Lockout,
  output logic       Alarm,
  output logic [1:0] FailCount,
  output logic [2:0] State
);

  // The timer expires on the cycle after it reads zero, so loading N-1 gives
  // exactly N cycles of timeout.
  localparam logic [TMR_W-1:0] IDLE_LD = TMR_W'(IDLE_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LOCK_LD = TMR_W'(LOCKOUT_CYCLES - 1);

  sup_state_e       st_q, st_d;
  logic             center_q, center_d;
  logic             cp_q, cp_d, lrst_q, lrst_d, lko_q, lko_d, alarm_q, alarm_d;
  logic [1:0]       fail_q, fail_d;
  logic             t_load, t_dec, t_zero;
  logic [TMR_W-1:0] t_val;
  logic             press, dial;

  assign press    = Center & ~center_q;
  assign dial     = Right | Left;
  assign center_d = Center;

  always_comb begin
    st_d    = st_q;
    cp_d    = 1'b0;
    lrst_d  = 1'b0;
    lko_d   = 1'b0;
    alarm_d = alarm_q;
    fail_d  = fail_q;
    t_load  = 1'b0;
    t_val   = IDLE_LD;
    t_dec   = 1'b0;
    case (st_q)
      S_IDLE: begin
        if (dial) begin
          st_d   = S_ARMED;
          t_load = 1'b1;
        end
      end
      S_ARMED: begin
        // A press beats a coincident expiry; dial activity also keeps it alive.
        if (press) begin
          cp_d   = 1'b1;
          st_d   = S_WAIT;
          t_load = 1'b1;
        end else if (dial) begin
          t_load = 1'b1;
        end else if (t_zero) begin
          lrst_d = 1'b1;
          st_d   = S_IDLE;
        end else begin
          t_dec  = 1'b1;
        end
      end
      S_WAIT: st_d = S_CHECK;
      S_CHECK: begin
        if (!Locked) begin
          st_d   = S_OPEN;
          fail_d = 2'd0;
        end else if ((int'(fail_q) + 1) < MAX_FAILS) begin
          fail_d = fail_q + 2'd1;
          lrst_d = 1'b1;
          st_d   = S_IDLE;
        end else begin
          fail_d  = 2'(MAX_FAILS);
          t_load  = 1'b1;
          t_val   = LOCK_LD;
          alarm_d = 1'b1;
          lko_d   = 1'b1;
          lrst_d  = 1'b1;
          st_d    = S_LOCKOUT;
        end
      end
      S_OPEN: begin
        if (Locked)     st_d = S_IDLE;
        else if (press) cp_d = 1'b1;
      end
      S_LOCKOUT: begin
        if (t_zero) begin
          st_d    = S_IDLE;
          fail_d  = 2'd0;
          alarm_d = 1'b0;
        end else begin
          lko_d  = 1'b1;
          lrst_d = 1'b1;
          t_dec  = 1'b1;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge South) begin
    if (South) begin
      st_q     <= S_IDLE;
      center_q <= 1'b0;
      cp_q     <= 1'b0;
      lrst_q   <= 1'b0;
      lko_q    <= 1'b0;
      alarm_q  <= 1'b0;
      fail_q   <= 2'd0;
    end else begin
      st_q     <= st_d;
      center_q <= center_d;
      cp_q     <= cp_d;
      lrst_q   <= lrst_d;
      lko_q    <= lko_d;
      alarm_q  <= alarm_d;
      fail_q   <= fail_d;
    end
  end

  lock_timer #(.TMR_W(TMR_W)) u_tmr (
    .clk      (Clk),
    .rst      (South),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  assign CenterPulse = cp_q;
  assign LockRst     = lrst_q;
  assign Lockout     = lko_q;
  assign Alarm       = alarm_q;
  assign FailCount   = fail_q;
  assign State       = st_q;

endmodule

// File: tb/tb_lock_attempt_supervisor.sv
// Bench for lock_attempt_supervisor: directed scenarios plus random traffic,
// all compared against a cycle-count reference model of the attempt rules.
module tb_lock_attempt_supervisor;
  import lock_pkg::*;

  localparam int MF = 3, LC = 20, IT = 10;

  logic       Clk = 1'b0, South = 1'b1;
  logic       Right = 1'b0, Left = 1'b0, Center = 1'b0, Locked = 1'b1;
  logic       CenterPulse, LockRst, Lockout, Alarm;
  logic [1:0] FailCount;
  logic [2:0] State;

  int n_chk = 0, n_fail = 0;

  // reference model: phase 0..5, quiet-cycle and lockout-elapsed counters
  int m_st, m_quiet, m_el, m_fail;
  bit m_pc, e_cp, e_lrst, e_alarm;
  bit code_ok, pend;

  wire [8:0] dut_v = {CenterPulse, LockRst, Lockout, Alarm, FailCount, State};

  lock_attempt_supervisor #(
    .MAX_FAILS(MF), .LOCKOUT_CYCLES(LC), .IDLE_TIMEOUT(IT), .TMR_W(26)
  ) dut (
    .Clk(Clk), .South(South), .Right(Right), .Left(Left), .Center(Center),
    .Locked(Locked), .CenterPulse(CenterPulse), .LockRst(LockRst),
    .Lockout(Lockout), .Alarm(Alarm), .FailCount(FailCount), .State(State)
  );

  always #5 Clk = ~Clk;

  function automatic logic [8:0] exp_v();
    return {e_cp, e_lrst, (m_st == 5), e_alarm, m_fail[1:0], m_st[2:0]};
  endfunction

  task automatic m_reset();
    m_st = 0; m_quiet = 0; m_el = 0; m_fail = 0;
    m_pc = 0; e_cp = 0; e_lrst = 0; e_alarm = 0;
  endtask

  task automatic m_step(input bit r, input bit l, input bit c, input bit lk);
    bit press;
    press = c && !m_pc;
    m_pc = c;
    e_cp = 0; e_lrst = 0;
    case (m_st)
      0: if (r || l) begin m_st = 1; m_quiet = 0; end
      1: if (press) begin e_cp = 1; m_st = 2; end
         else if (r || l) m_quiet = 0;
         else begin
           m_quiet++;
           if (m_quiet >= IT) begin e_lrst = 1; m_st = 0; end
         end
      2: m_st = 3;
      3: if (!lk) begin m_st = 4; m_fail = 0; end
         else if (m_fail + 1 < MF) begin m_fail++; e_lrst = 1; m_st = 0; end
         else begin m_fail = MF; e_alarm = 1; m_st = 5; m_el = 0; end
      4: if (lk) m_st = 0; else if (press) e_cp = 1;
      5: begin
           m_el++;
           if (m_el >= LC) begin m_st = 0; m_fail = 0; e_alarm = 0; end
         end
      default: m_st = 0;
    endcase
    if (m_st == 5) e_lrst = 1;
  endtask

  // One clock: model steps on the edge; the emulated lock FSM reacts to a
  // strobe one cycle later (opens on a good code, relocks when open).
  task automatic cyc();
    @(posedge Clk);
    m_step(Right, Left, Center, Locked);
    @(negedge Clk);
    if (e_lrst) Locked = 1'b1;
    else if (pend) Locked = Locked ? !code_ok : 1'b1;
    pend = e_cp;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    South = 1'b1; Right = 0; Left = 0; Center = 0; Locked = 1'b1; pend = 0;
    m_reset();
    @(negedge Clk);
    South = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if (dut_v !== 9'd0) begin n_fail++; $display("FAIL reset_state: got %b want %b", dut_v, 9'd0); end
    Right = 1; Center = 1;
    @(posedge Clk); #1;
    n_chk++;
    if (dut_v !== 9'd0) begin n_fail++; $display("FAIL reset_hold: got %b want %b", dut_v, 9'd0); end
    do_reset();
  endtask

  task automatic test_correct_entry();
    logic [2:0] t [9] = '{3'b100, 3'b001, 3'b001, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000};
    int cpn = 0;
    do_reset(); code_ok = 1;
    for (int i = 0; i < 9; i++) begin
      {Right, Left, Center} = t[i];
      cyc();
      cpn += int'(CenterPulse);
      n_chk++;
      if (dut_v !== exp_v()) begin n_fail++; $display("FAIL entry_c%0d: got %b want %b", i, dut_v, exp_v()); end
      if (i == 3) begin
        n_chk++;
        if (State !== 3'd4) begin n_fail++; $display("FAIL entry_open: got %0d want 4", State); end
      end
    end
    n_chk++;
    if (cpn != 2 || State !== 3'd0 || FailCount !== 2'd0) begin
      n_fail++; $display("FAIL entry_summary: pulses %0d state %0d fails %0d want 2 0 0", cpn, State, FailCount);
    end
  endtask

  task automatic test_single_failure();
    logic [2:0] t [5] = '{3'b100, 3'b001, 3'b000, 3'b000, 3'b000};
    int lrn = 0;
    do_reset(); code_ok = 0;
    for (int i = 0; i < 5; i++) begin
      {Right, Left, Center} = t[i];
      cyc();
      lrn += int'(LockRst);
      n_chk++;
      if (dut_v !== exp_v()) begin n_fail++; $display("FAIL fail1_c%0d: got %b want %b", i, dut_v, exp_v()); end
    end
    n_chk++;
    if (lrn != 1 || FailCount !== 2'd1 || State !== 3'd0) begin
      n_fail++; $display("FAIL fail1_summary: lockrst %0d fails %0d state %0d want 1 1 0", lrn, FailCount, State);
    end
  endtask

  task automatic test_lockout();
    logic [2:0] t [5] = '{3'b100, 3'b001, 3'b000, 3'b000, 3'b000};
    int lko_n = 0, alm_n = 0, cp_in = 0, gap = 0, maxf = 0;
    do_reset(); code_ok = 0;
    for (int i = 0; i < 37; i++) begin
      if (i < 15) {Right, Left, Center} = t[i % 5];
      else begin
        Right  = (m_st == 5) ? 1'($urandom_range(0, 1)) : 1'b0;
        Left   = 1'b0;
        Center = (m_st == 5) ? 1'(i % 2) : 1'b0;
      end
      cyc();
      lko_n += int'(Lockout);
      alm_n += int'(Alarm);
      if (Lockout) cp_in += int'(CenterPulse);
      if (Lockout && !LockRst) gap++;
      if (int'(FailCount) > maxf) maxf = int'(FailCount);
      n_chk++;
      if (dut_v !== exp_v()) begin n_fail++; $display("FAIL lockout_c%0d: got %b want %b", i, dut_v, exp_v()); end
    end
    n_chk++;
    if (lko_n != LC || alm_n != LC || maxf != 3) begin
      n_fail++; $display("FAIL lockout_len: lockout %0d alarm %0d maxfail %0d want %0d %0d 3", lko_n, alm_n, maxf, LC, LC);
    end
    n_chk++;
    if (cp_in != 0 || gap != 0) begin
      n_fail++; $display("FAIL lockout_block: pulses %0d rst_gaps %0d want 0 0", cp_in, gap);
    end
    n_chk++;
    if (State !== 3'd0 || FailCount !== 2'd0 || Alarm !== 1'b0 || Lockout !== 1'b0) begin
      n_fail++; $display("FAIL lockout_exit: state %0d fails %0d alarm %b lockout %b want 0 0 0 0", State, FailCount, Alarm, Lockout);
    end
  endtask

  task automatic test_idle_timeout();
    logic [2:0] t [5] = '{3'b100, 3'b001, 3'b000, 3'b000, 3'b000};
    int lrn = 0;
    do_reset(); code_ok = 0;
    for (int i = 0; i < 27; i++) begin
      if (i < 5)        {Right, Left, Center} = t[i];
      else if (i == 5)  {Right, Left, Center} = 3'b100;
      else if (i == 16) {Right, Left, Center} = 3'b100;
      else if (i == 25) {Right, Left, Center} = 3'b010;
      else              {Right, Left, Center} = 3'b000;
      cyc();
      if (i >= 5 && i <= 15) lrn += int'(LockRst);
      n_chk++;
      if (dut_v !== exp_v()) begin n_fail++; $display("FAIL idle_c%0d: got %b want %b", i, dut_v, exp_v()); end
      if (i == 15) begin
        n_chk++;
        if (LockRst !== 1'b1 || lrn != 1 || State !== 3'd0 || FailCount !== 2'd1) begin
          n_fail++; $display("FAIL idle_expire: lockrst %b count %0d state %0d fails %0d want 1 1 0 1", LockRst, lrn, State, FailCount);
        end
      end
      if (i == 26) begin
        n_chk++;
        if (LockRst !== 1'b0 || State !== 3'd1) begin
          n_fail++; $display("FAIL idle_reload: lockrst %b state %0d want 0 1", LockRst, State);
        end
      end
    end
  endtask

  task automatic test_held_center();
    int cpn = 0;
    do_reset(); code_ok = 0;
    for (int i = 0; i < 36; i++) begin
      if (i == 0 || i == 20)      {Right, Left, Center} = 3'b100;
      else if (i <= 15 || i == 30) {Right, Left, Center} = 3'b001;
      else                         {Right, Left, Center} = 3'b000;
      cyc();
      if (i <= 19) cpn += int'(CenterPulse);
      n_chk++;
      if (dut_v !== exp_v()) begin n_fail++; $display("FAIL held_c%0d: got %b want %b", i, dut_v, exp_v()); end
      if (i == 19) begin
        n_chk++;
        if (cpn != 1) begin n_fail++; $display("FAIL held_one_pulse: got %0d want 1", cpn); end
      end
      if (i == 30) begin
        n_chk++;
        if (CenterPulse !== 1'b1 || LockRst !== 1'b0) begin
          n_fail++; $display("FAIL press_on_expiry: pulse %b lockrst %b want 1 0", CenterPulse, LockRst);
        end
      end
    end
  endtask

  task automatic test_async_reset_lockout();
    logic [2:0] t [5] = '{3'b100, 3'b001, 3'b000, 3'b000, 3'b000};
    do_reset(); code_ok = 0;
    for (int i = 0; i < 26; i++) begin
      {Right, Left, Center} = (i < 15) ? t[i % 5] : 3'b000;
      cyc();
    end
    n_chk++;
    if (Lockout !== 1'b1 || Alarm !== 1'b1 || dut_v !== exp_v()) begin
      n_fail++; $display("FAIL pre_reset_lockout: got %b want %b", dut_v, exp_v());
    end
    #2 South = 1'b1;
    #1;
    n_chk++;
    if (dut_v !== 9'd0) begin n_fail++; $display("FAIL async_reset: got %b want %b", dut_v, 9'd0); end
    @(negedge Clk);
    South = 1'b0; Locked = 1'b1; pend = 0;
    m_reset();
    Right = 1'b1;
    cyc();
    Right = 1'b0;
    n_chk++;
    if (dut_v !== exp_v()) begin n_fail++; $display("FAIL after_reset: got %b want %b", dut_v, exp_v()); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 799) == 0) begin
        South = 1'b1;
        #1;
        n_chk++;
        if (dut_v !== 9'd0) begin n_fail++; $display("FAIL rand_reset_%0d: got %b want %b", i, dut_v, 9'd0); end
        @(negedge Clk);
        South = 1'b0; Locked = 1'b1; pend = 0;
        m_reset();
      end
      Right   = ($urandom_range(0, 19) == 0);
      Left    = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) Center = ~Center;
      code_ok = 1'($urandom_range(0, 1));
      cyc();
      n_chk++;
      if (dut_v !== exp_v()) begin n_fail++; $display("FAIL rand_c%0d: got %b want %b", i, dut_v, exp_v()); end
    end
  endtask

  initial begin
    m_reset(); pend = 0; code_ok = 0;
    test_reset();
    test_correct_entry();
    test_single_failure();
    test_lockout();
    test_idle_timeout();
    test_held_center();
    test_async_reset_lockout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
